// File: rtl/gabor_window_scheduler.sv
// rtl/gabor_window_scheduler.sv - padded-image BRAM read sequencer for KxK Gabor windows
//
// Purpose: for each output pixel (x,y) in raster order, issue K*K tap reads
// starting at window base y*PAD_W+x, tag each returned tap for the MAC array,
// and frame the whole image with busy/done.
//
// Ports:
//   clk        in   1       clock
//   rst        in   1       asynchronous active-high reset
//   start      in   1       begin frame (sampled only when idle)
//   win_ready  in   1       MAC can accept a full K*K window
//   busy       out  1       high in every state except IDLE
//   done       out  1       1-cycle pulse once the last window has drained
//   bram_en    out  1       BRAM read enable
//   bram_addr  out  ADDR_W  BRAM read address
//   tap_valid  out  1       BRAM data valid (bram_en delayed RD_LAT)
//   tap_idx    out  5       tap index r*K+c aligned with tap_valid
//   tap_last   out  1       final tap of a window is valid
//   out_x      out  9       column of window in flight
//   out_y      out  9       row of window in flight
module gabor_window_scheduler #(
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512,
   parameter int K      = 5,
   parameter int PAD_W  = 516,
   parameter int ADDR_W = 19,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              win_ready,
   output logic              busy,
   output logic              done,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              tap_valid,
   output logic [4:0]        tap_idx,
   output logic              tap_last,
   output logic [8:0]        out_x,
   output logic [8:0]        out_y
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_ISSUE, S_DRAIN, S_NEXT} state_t;

   localparam logic [4:0]        LAST_TAP  = 5'(K*K-1);
   localparam logic [4:0]        LAST_COL  = 5'(K-1);
   localparam logic [8:0]        LAST_X    = 9'(IMG_W-1);
   localparam logic [8:0]        LAST_Y    = 9'(IMG_H-1);
   localparam logic [7:0]        LAST_DRN  = 8'(RD_LAT-1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(PAD_W);
   // Moving from column IMG_W-1 of row y to column 0 of row y+1 skips the padding.
   localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(PAD_W-IMG_W+1);

   state_t            state_q, state_d;
   logic [8:0]        x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0] win_base_q, win_base_d, row_ptr_q, row_ptr_d;
   logic [4:0]        c_q, c_d, tap_q, tap_d;
   logic [7:0]        drn_q, drn_d;
   logic              done_q, done_d;
   logic [RD_LAT-1:0] vld_q;
   logic [4:0]        idx_q [RD_LAT];
   logic              last_win;

   assign last_win = (x_q == LAST_X) && (y_q == LAST_Y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         win_base_q <= '0;
         row_ptr_q  <= '0;
         c_q        <= '0;
         tap_q      <= '0;
         drn_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         win_base_q <= win_base_d;
         row_ptr_q  <= row_ptr_d;
         c_q        <= c_d;
         tap_q      <= tap_d;
         drn_q      <= drn_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      win_base_d = win_base_q;
      row_ptr_d  = row_ptr_q;
      c_d        = c_q;
      tap_d      = tap_q;
      drn_d      = drn_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WAIT_RDY;
               x_d        = '0;
               y_d        = '0;
               win_base_d = '0;
            end
         end
         S_WAIT_RDY: begin
            if (win_ready) begin
               state_d   = S_ISSUE;
               row_ptr_d = win_base_q;
               c_d       = '0;
               tap_d     = '0;
            end
         end
         S_ISSUE: begin
            tap_d = tap_q + 5'd1;
            if (c_q == LAST_COL) begin
               c_d       = '0;
               row_ptr_d = row_ptr_q + ROW_STEP;
            end else begin
               c_d = c_q + 5'd1;
            end
            if (tap_q == LAST_TAP) begin
               state_d = S_DRAIN;
               tap_d   = '0;
               drn_d   = '0;
            end
         end
         S_DRAIN: begin
            drn_d = drn_q + 8'd1;
            if (drn_q == LAST_DRN) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (last_win) begin
               // done is registered so it lands in the first idle cycle,
               // coinciding with busy falling.
               state_d    = S_IDLE;
               done_d     = 1'b1;
               x_d        = '0;
               y_d        = '0;
               win_base_d = '0;
            end else begin
               state_d = S_WAIT_RDY;
               if (x_q == LAST_X) begin
                  x_d        = '0;
                  y_d        = y_q + 9'd1;
                  win_base_d = win_base_q + WRAP_STEP;
               end else begin
                  x_d        = x_q + 9'd1;
                  win_base_d = win_base_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bram_en   = (state_q == S_ISSUE);
   assign bram_addr = bram_en ? (row_ptr_q + ADDR_W'(c_q)) : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign out_x     = x_q;
   assign out_y     = y_q;

   // Read-latency matching pipe for the valid flag and tap tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
      end else begin
         vld_q[0] <= bram_en;
         idx_q[0] <= bram_en ? tap_q : 5'd0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   assign tap_valid = vld_q[RD_LAT-1];
   assign tap_idx   = idx_q[RD_LAT-1];
   assign tap_last  = tap_valid && (tap_idx == LAST_TAP);

endmodule

// File: tb/tb_gabor_window_scheduler.sv
// tb/tb_gabor_window_scheduler.sv - self-checking bench for gabor_window_scheduler
module tb_gabor_window_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic        rst_b, start_b, wr_b;
   logic        busy_b, done_b, en_b, tv_b, last_b;
   logic [18:0] addr_b;
   logic [4:0]  idx_b;
   logic [8:0]  ox_b, oy_b;

   // small-frame instance, RD_LAT=3
   logic        rst_s, start_s, wr_s;
   logic        busy_s, done_s, en_s, tv_s, last_s;
   logic [18:0] addr_s;
   logic [4:0]  idx_s;
   logic [8:0]  ox_s, oy_s;

   gabor_window_scheduler u_big (
      .clk(clk), .rst(rst_b), .start(start_b), .win_ready(wr_b),
      .busy(busy_b), .done(done_b), .bram_en(en_b), .bram_addr(addr_b),
      .tap_valid(tv_b), .tap_idx(idx_b), .tap_last(last_b),
      .out_x(ox_b), .out_y(oy_b)
   );

   gabor_window_scheduler #(
      .IMG_W(4), .IMG_H(2), .K(5), .PAD_W(8), .ADDR_W(19), .RD_LAT(3)
   ) u_small (
      .clk(clk), .rst(rst_s), .start(start_s), .win_ready(wr_s),
      .busy(busy_s), .done(done_s), .bram_en(en_s), .bram_addr(addr_s),
      .tap_valid(tv_s), .tap_idx(idx_s), .tap_last(last_s),
      .out_x(ox_s), .out_y(oy_s)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic start;
      logic wr;
      logic busy;
      logic en;
      int   addr;
      logic tv;
      int   idx;
      logic last;
      int   ox;
   } vec_t;

   vec_t vt[30];
   int   row_base[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      int en_cnt, tl_cnt, done_cnt, addr_err, lag_err, mw, mt, exp_a;
      int cyc, done_cyc, last_tl_cyc, last_addr;
      logic busy_at_done, prev_busy, busy_before_done;
      logic [2:0] en_hist;

      row_base = '{0, 516, 1032, 1548, 2064};
      for (int j = 0; j < 30; j++) begin
         vt[j] = '{start: (j == 0), wr: 1'b1, busy: 1'b1, en: 1'b0, addr: 0,
                   tv: 1'b0, idx: 0, last: 1'b0, ox: 0};
         if (j >= 1 && j <= 25) begin
            vt[j].en   = 1'b1;
            vt[j].addr = row_base[(j-1)/5] + (j-1)%5;
         end
         if (j >= 2 && j <= 26) begin
            vt[j].tv   = 1'b1;
            vt[j].idx  = j - 2;
            vt[j].last = (j == 26);
         end
         if (j >= 28) vt[j].ox = 1;
         if (j == 29) begin
            vt[j].en   = 1'b1;
            vt[j].addr = 1;
         end
      end

      rst_b = 1'b1; start_b = 1'b0; wr_b = 1'b0;
      rst_s = 1'b1; start_s = 1'b0; wr_s = 1'b0;
      step(); step();
      rst_b = 1'b0; rst_s = 1'b0;
      step();

      // reset state
      chk("rst_busy", 32'(busy_b), 0);
      chk("rst_done", 32'(done_b), 0);
      chk("rst_en", 32'(en_b), 0);
      chk("rst_addr", 32'(addr_b), 0);
      chk("rst_tv", 32'(tv_b), 0);
      chk("rst_idx", 32'(idx_b), 0);
      chk("rst_last", 32'(last_b), 0);
      chk("rst_ox", 32'(ox_b), 0);
      chk("rst_oy", 32'(oy_b), 0);

      // window (0,0) and first cycles of (1,0)
      for (int j = 0; j < 30; j++) begin
         start_b = vt[j].start;
         wr_b    = vt[j].wr;
         step();
         chk($sformatf("v%0d_busy", j), 32'(busy_b), 32'(vt[j].busy));
         chk($sformatf("v%0d_en", j), 32'(en_b), 32'(vt[j].en));
         chk($sformatf("v%0d_addr", j), 32'(addr_b), vt[j].addr);
         chk($sformatf("v%0d_tv", j), 32'(tv_b), 32'(vt[j].tv));
         chk($sformatf("v%0d_idx", j), 32'(idx_b), vt[j].idx);
         chk($sformatf("v%0d_last", j), 32'(last_b), 32'(vt[j].last));
         chk($sformatf("v%0d_ox", j), 32'(ox_b), vt[j].ox);
      end
      start_b = 1'b0;

      // row end: window (511,0) then wrap to (0,1)
      found = 0;
      for (int i = 0; i < 20000 && found == 0; i++) begin
         step();
         if (en_b && ox_b == 9'd511) found = 1;
      end
      chk("w511_found", 32'(found), 1);
      for (int t = 0; t < 5; t++) begin
         chk($sformatf("w511_addr%0d", t), 32'(addr_b), 32'(511 + t));
         step();
      end
      chk("w511_oy", 32'(oy_b), 0);
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         step();
         if (en_b && oy_b == 9'd1) found = 1;
      end
      chk("w01_found", 32'(found), 1);
      chk("w01_ox", 32'(ox_b), 0);
      chk("w01_oy", 32'(oy_b), 1);
      chk("w01_addr", 32'(addr_b), 516);

      // drop win_ready and pulse start mid-ISSUE: window still issues whole
      wr_b = 1'b0; start_b = 1'b1;
      en_cnt = 0; addr_err = 0;
      for (int t = 1; t < 25; t++) begin
         step();
         start_b = 1'b0;
         if (en_b) en_cnt++;
         if (addr_b != 19'(516 + (t/5)*516 + t%5)) addr_err++;
      end
      chk("mid_issue_en_cnt", 32'(en_cnt), 24);
      chk("mid_issue_addr_err", 32'(addr_err), 0);
      chk("mid_issue_oy", 32'(oy_b), 1);
      step();
      chk("drain_en", 32'(en_b), 0);
      chk("drain_last", 32'(last_b), 1);
      step();
      step();
      chk("wait_ox", 32'(ox_b), 1);
      chk("wait_busy", 32'(busy_b), 1);

      // stall in WAIT_RDY for 10 cycles
      en_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (en_b) en_cnt++;
      end
      chk("stall_en_cnt", 32'(en_cnt), 0);
      wr_b = 1'b1;
      step();
      chk("resume_en", 32'(en_b), 1);
      chk("resume_addr", 32'(addr_b), 517);

      // reset during tap 12 of window (3,0)
      rst_b = 1'b1;
      step();
      rst_b = 1'b0; start_b = 1'b1;
      step();
      start_b = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         step();
         if (en_b && ox_b == 9'd3) found = 1;
      end
      chk("w3_found", 32'(found), 1);
      for (int i = 0; i < 12; i++) step();
      chk("w3_tap12_addr", 32'(addr_b), 1037);
      chk("w3_tap12_idx", 32'(idx_b), 11);
      rst_b = 1'b1;
      step();
      chk("abort_busy", 32'(busy_b), 0);
      chk("abort_en", 32'(en_b), 0);
      chk("abort_addr", 32'(addr_b), 0);
      chk("abort_tv", 32'(tv_b), 0);
      chk("abort_idx", 32'(idx_b), 0);
      chk("abort_ox", 32'(ox_b), 0);
      chk("abort_done", 32'(done_b), 0);
      rst_b = 1'b0; start_b = 1'b1;
      step();
      start_b = 1'b0;
      chk("restart_wait_tv", 32'(tv_b), 0);
      chk("restart_wait_busy", 32'(busy_b), 1);
      step();
      chk("restart_en", 32'(en_b), 1);
      chk("restart_addr", 32'(addr_b), 0);
      chk("restart_tv", 32'(tv_b), 0);
      step();
      chk("restart_tv1", 32'(tv_b), 1);
      chk("restart_idx", 32'(idx_b), 0);
      wr_b = 1'b0;

      // full small frame: RD_LAT=3, 4x2 windows, row stride 8
      en_cnt = 0; tl_cnt = 0; done_cnt = 0; addr_err = 0; lag_err = 0;
      mw = 0; mt = 0; cyc = 0; done_cyc = -1; last_tl_cyc = -1; last_addr = -1;
      en_hist = 3'b000; prev_busy = 1'b0; busy_at_done = 1'b1; busy_before_done = 1'b0;
      start_s = 1'b1; wr_s = 1'b1;
      step();
      start_s = 1'b0;
      for (int i = 0; i < 400 && done_cnt == 0; i++) begin
         step();
         cyc++;
         if (tv_s != en_hist[2]) lag_err++;
         en_hist = {en_hist[1:0], en_s};
         if (en_s) begin
            exp_a = ((mw/4) + mt/5)*8 + (mw%4) + mt%5;
            if (32'(addr_s) != exp_a) addr_err++;
            last_addr = int'(addr_s);
            en_cnt++;
            mt++;
            if (mt == 25) begin mt = 0; mw++; end
         end
         if (last_s) begin tl_cnt++; last_tl_cyc = cyc; end
         if (done_s) begin
            done_cnt++; done_cyc = cyc; busy_at_done = busy_s; busy_before_done = prev_busy;
         end
         prev_busy = busy_s;
      end
      for (int i = 0; i < 5; i++) begin
         step();
         if (done_s) done_cnt++;
      end
      chk("frame_en_cnt", 32'(en_cnt), 200);
      chk("frame_addr_err", 32'(addr_err), 0);
      chk("frame_last_addr", 32'(last_addr), 47);
      chk("frame_tap_last_cnt", 32'(tl_cnt), 8);
      chk("frame_lag_err", 32'(lag_err), 0);
      chk("frame_done_cnt", 32'(done_cnt), 1);
      chk("frame_done_delay", 32'(done_cyc - last_tl_cyc), 2);
      chk("frame_busy_at_done", 32'(busy_at_done), 0);
      chk("frame_busy_before_done", 32'(busy_before_done), 1);
      chk("frame_idle_busy", 32'(busy_s), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
